// File: rtl/rocc_acc_pkg.sv
// Shared types for the RoCC accumulator unit.
// ROCC_ACC_MAC_EN enables the iterative multiply-accumulate op.
package rocc_acc_pkg;

    // Command payload width; the unit's XLEN must not exceed it.
    localparam int unsigned ROCC_DATA_W = 64;
    localparam int unsigned ROCC_OP_W   = 3;

    typedef enum logic [ROCC_OP_W-1:0] {
        OP_WRITE = 3'd0,
        OP_READ  = 3'd1,
        OP_ACCUM = 3'd2,
        OP_CLEAR = 3'd3,
        OP_MAC   = 3'd4
    } rocc_acc_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } rocc_acc_state_e;

    typedef struct packed {
        logic [6:0]             funct;
        logic [ROCC_DATA_W-1:0] rs1;
        logic [ROCC_DATA_W-1:0] rs2;
        logic [4:0]             rd;
        logic                   xd;
    } rocc_acc_cmd_t;

endpackage

// File: rtl/rocc_cmd_fifo.sv
// Registered command FIFO, no bypass.
// Full blocks pushes even when a pop happens in the same cycle.
module rocc_cmd_fifo
    import rocc_acc_pkg::*;
#(
    parameter type         T     = rocc_acc_cmd_t,
    parameter int unsigned DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= ptr_inc(wr_q);
            end
            if (do_pop) begin
                rd_q <= ptr_inc(rd_q);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rocc_acc_unit.sv
// RoCC accumulator accelerator: FIFO, FSM, accumulator file.
// ROCC_ACC_MAC_EN builds the XLEN-cycle shift-add MAC path.
module rocc_acc_unit
    import rocc_acc_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned NUM_ACC   = 4,
    parameter int unsigned CMD_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [6:0]      cmd_funct_i,
    input  logic [XLEN-1:0] cmd_rs1_i,
    input  logic [XLEN-1:0] cmd_rs2_i,
    input  logic [4:0]      cmd_rd_i,
    input  logic            cmd_xd_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_data_o,
    output logic [4:0]      resp_rd_o,
    output logic            busy_o
);

    localparam int unsigned IDX_W = $clog2(NUM_ACC);

    rocc_acc_state_e state_q, state_d;
    rocc_acc_cmd_t   push_cmd, head_cmd;
    logic            fifo_full, fifo_empty, fifo_pop;

    logic [XLEN-1:0]  acc_q [NUM_ACC];
    logic [XLEN-1:0]  resp_data_q;
    logic [4:0]       resp_rd_q;

    logic [2:0]       head_op;
    logic [IDX_W-1:0] head_idx;
    logic [XLEN-1:0]  head_rs1, head_rs2, acc_rd;
    logic             head_is_mac;
    logic             sc_we;
    logic [XLEN-1:0]  sc_wdata, sc_result;
    logic             unused_bits;

    assign push_cmd = '{
        funct: cmd_funct_i,
        rs1:   ROCC_DATA_W'(cmd_rs1_i),
        rs2:   ROCC_DATA_W'(cmd_rs2_i),
        rd:    cmd_rd_i,
        xd:    cmd_xd_i
    };

    rocc_cmd_fifo #(
        .T     (rocc_acc_cmd_t),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (cmd_valid_i),
        .data_i  (push_cmd),
        .pop_i   (fifo_pop),
        .data_o  (head_cmd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_op     = head_cmd.funct[2:0];
    assign head_idx    = head_cmd.funct[3 +: IDX_W];
    assign head_rs1    = head_cmd.rs1[XLEN-1:0];
    assign head_rs2    = head_cmd.rs2[XLEN-1:0];
    assign acc_rd      = acc_q[head_idx];
    assign unused_bits = ^{head_cmd.funct, head_cmd.rs1, head_cmd.rs2};

`ifdef ROCC_ACC_MAC_EN
    localparam int unsigned CNT_W = $clog2(XLEN);

    logic [XLEN-1:0]  mul_a_q, mul_b_q, prod_q, step_sum, mac_sum;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] mac_idx_q;
    logic [4:0]       mac_rd_q;
    logic             mac_xd_q, mac_last;

    assign head_is_mac = (head_op == OP_MAC);
    assign step_sum    = prod_q + (mul_b_q[0] ? mul_a_q : '0);
    assign mac_sum     = acc_q[mac_idx_q] + step_sum;
    assign mac_last    = (cnt_q == CNT_W'(XLEN - 1));
`else
    assign head_is_mac = 1'b0;
`endif

    // Single-cycle ops; anything not decoded here answers all ones.
    always_comb begin
        sc_we     = 1'b0;
        sc_wdata  = acc_rd;
        sc_result = '1;
        unique case (1'b1)
            (head_op == OP_WRITE): begin
                sc_we     = 1'b1;
                sc_wdata  = head_rs1;
                sc_result = head_rs1;
            end
            (head_op == OP_READ): begin
                sc_result = acc_rd;
            end
            (head_op == OP_ACCUM): begin
                sc_we     = 1'b1;
                sc_wdata  = acc_rd + head_rs1;
                sc_result = acc_rd + head_rs1;
            end
            (head_op == OP_CLEAR): begin
                sc_we     = 1'b1;
                sc_wdata  = '0;
                sc_result = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    if (head_is_mac) begin
                        state_d = EXEC;
                    end else if (head_cmd.xd) begin
                        state_d = RESP;
                    end
                end
            end
            EXEC: begin
`ifdef ROCC_ACC_MAC_EN
                if (mac_last) begin
                    state_d = mac_xd_q ? RESP : IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_pop     = (state_q == IDLE) && !fifo_empty;
        cmd_ready_o  = !fifo_full;
        resp_valid_o = (state_q == RESP);
        busy_o       = !fifo_empty || (state_q != IDLE);
    end

    assign resp_data_o = resp_data_q;
    assign resp_rd_o   = resp_rd_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                acc_q[i] <= '0;
            end
            resp_data_q <= '0;
            resp_rd_q   <= '0;
        end else begin
            if (fifo_pop && !head_is_mac) begin
                if (sc_we) begin
                    acc_q[head_idx] <= sc_wdata;
                end
                if (head_cmd.xd) begin
                    resp_data_q <= sc_result;
                    resp_rd_q   <= head_cmd.rd;
                end
            end
`ifdef ROCC_ACC_MAC_EN
            if (state_q == EXEC && mac_last) begin
                acc_q[mac_idx_q] <= mac_sum;
                if (mac_xd_q) begin
                    resp_data_q <= mac_sum;
                    resp_rd_q   <= mac_rd_q;
                end
            end
`endif
        end
    end

`ifdef ROCC_ACC_MAC_EN
    // Shift-add multiplier: one bit of rs2 per EXEC cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            mac_idx_q <= '0;
            mac_rd_q  <= '0;
            mac_xd_q  <= 1'b0;
        end else if (fifo_pop && head_is_mac) begin
            mul_a_q   <= head_rs1;
            mul_b_q   <= head_rs2;
            prod_q    <= '0;
            cnt_q     <= '0;
            mac_idx_q <= head_idx;
            mac_rd_q  <= head_cmd.rd;
            mac_xd_q  <= head_cmd.xd;
        end else if (state_q == EXEC) begin
            prod_q  <= step_sum;
            mul_a_q <= {mul_a_q[XLEN-2:0], 1'b0};
            mul_b_q <= {1'b0, mul_b_q[XLEN-1:1]};
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end
`else
    logic unused_rs2;
    assign unused_rs2 = ^head_rs2;
`endif

endmodule

// File: tb/tb_rocc_acc_unit.sv
// Self-checking bench for rocc_acc_unit (XLEN=64, NUM_ACC=4, CMD_DEPTH=2).
module tb_rocc_acc_unit;

    localparam int XLEN = 64;
`ifdef ROCC_ACC_MAC_EN
    localparam bit MAC_EN = 1'b1;
`else
    localparam bit MAC_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [6:0]      cmd_funct;
    logic [XLEN-1:0] cmd_rs1, cmd_rs2;
    logic [4:0]      cmd_rd;
    logic            cmd_xd;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic [4:0]      resp_rd;
    logic            busy;

    rocc_acc_unit #(.XLEN(XLEN), .NUM_ACC(4), .CMD_DEPTH(2)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_funct_i  (cmd_funct),
        .cmd_rs1_i    (cmd_rs1),
        .cmd_rs2_i    (cmd_rs2),
        .cmd_rd_i     (cmd_rd),
        .cmd_xd_i     (cmd_xd),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .resp_rd_o    (resp_rd),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    logic [63:0] acc_m [4];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference: plain arithmetic on an array of accumulators.
    function automatic logic [63:0] model(input logic [6:0] f, input logic [63:0] a,
                                          input logic [63:0] b);
        int i;
        i = int'(f[4:3]);
        case (f[2:0])
            3'd0: acc_m[i] = a;
            3'd1: ;
            3'd2: acc_m[i] = acc_m[i] + a;
            3'd3: acc_m[i] = 64'd0;
            3'd4: begin
                if (!MAC_EN) return '1;
                acc_m[i] = acc_m[i] + a * b;
            end
            default: return '1;
        endcase
        return acc_m[i];
    endfunction

    task automatic send(input logic [6:0] f, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd, input logic xd);
        logic acc;
        int   g;
        g = 0;
        cmd_valid = 1'b1; cmd_funct = f; cmd_rs1 = a; cmd_rs2 = b;
        cmd_rd = rd; cmd_xd = xd;
        do begin
            acc = cmd_ready;
            @(posedge clk); #1;
            g++;
        end while (!acc && g < 20000);
        cmd_valid = 1'b0;
        if (!acc) begin
            total++;
            $display("FAIL send_timeout: got ready 0 expected 1");
        end
    endtask

    task automatic get_resp(output logic [63:0] d, output logic [4:0] r, output int n);
        n = 0;
        resp_ready = 1'b1;
        while (!resp_valid && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        d = resp_data;
        r = resp_rd;
        if (!resp_valid) begin
            total++;
            $display("FAIL resp_timeout: got valid 0 expected 1");
            n = -1;
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        #2 rst_ni = 1'b0;
        #3 rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) acc_m[i] = 64'd0;
    endtask

    typedef struct {
        logic [6:0]  funct;
        logic [63:0] rs1;
        logic [4:0]  rd;
        logic [63:0] exp;
    } vec_t;

    localparam int NR = 120;

    initial begin
        vec_t        tbl [10];
        logic [63:0] d;
        logic [4:0]  r;
        int          n;
        logic        seen;
        logic [6:0]  rf  [NR];
        logic [63:0] ra  [NR];
        logic [63:0] rb  [NR];
        logic [4:0]  rrd [NR];
        logic        rxd [NR];
        logic [63:0] exp_d [$];
        logic [4:0]  exp_r [$];

        tbl[0] = '{7'h18, 64'h1234, 5'd9, 64'h1234};
        tbl[1] = '{7'h1A, 64'h10, 5'd10, 64'h1244};
        tbl[2] = '{7'h19, 64'h0, 5'd11, 64'h1244};
        tbl[3] = '{7'h1B, 64'h55, 5'd12, 64'h0};
        tbl[4] = '{7'h12, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[5] = '{7'h12, 64'h2, 5'd14, 64'h1};
        tbl[6] = '{7'h15, 64'h9, 5'd15, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[7] = '{7'h16, 64'h9, 5'd16, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[8] = '{7'h11, 64'h0, 5'd17, 64'h1};
        tbl[9] = '{7'h61, 64'h0, 5'd18, 64'h0};

        rst_ni = 1'b0; cmd_valid = 1'b0; cmd_funct = '0; cmd_rs1 = '0;
        cmd_rs2 = '0; cmd_rd = '0; cmd_xd = 1'b0; resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) acc_m[i] = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_resp_rd", 64'(resp_rd), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // READ of a fresh accumulator and its latency.
        send(7'h11, 64'd0, 64'd0, 5'd3, 1'b1);
        get_resp(d, r, n);
        chk("read_data", d, 64'd0);
        chk("read_rd", 64'(r), 64'd3);
        chk("read_latency", 64'(n), 64'd1);

        // Wrapping accumulate.
        send(7'h08, 64'd5, 64'd0, 5'd0, 1'b0);
        send(7'h0A, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 5'd7, 1'b1);
        get_resp(d, r, n);
        chk("accum_wrap_data", d, 64'd3);
        chk("accum_wrap_rd", 64'(r), 64'd7);

        // Response backpressure with the FIFO filling up.
        resp_ready = 1'b0;
        send(7'h09, 64'd0, 64'd0, 5'd1, 1'b1);
        send(7'h01, 64'd0, 64'd0, 5'd2, 1'b1);
        send(7'h11, 64'd0, 64'd0, 5'd3, 1'b1);
        chk("bp_cmd_ready_low", 64'(cmd_ready), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_hold_valid", 64'(resp_valid), 64'd1);
        chk("bp_hold_data", resp_data, 64'd3);
        chk("bp_hold_rd", 64'(resp_rd), 64'd1);
        get_resp(d, r, n);
        chk("bp_r0_data", d, 64'd3);
        chk("bp_r0_rd", 64'(r), 64'd1);
        get_resp(d, r, n);
        chk("bp_r1_data", d, 64'd0);
        chk("bp_r1_rd", 64'(r), 64'd2);
        get_resp(d, r, n);
        chk("bp_r2_data", d, 64'd0);
        chk("bp_r2_rd", 64'(r), 64'd3);

        // Illegal op 7 with and without a response.
        send(7'h0F, 64'd99, 64'd0, 5'd6, 1'b1);
        get_resp(d, r, n);
        chk("illegal_data", d, 64'hFFFF_FFFF_FFFF_FFFF);
        send(7'h09, 64'd0, 64'd0, 5'd6, 1'b1);
        get_resp(d, r, n);
        chk("illegal_no_change", d, 64'd3);
        send(7'h0F, 64'd99, 64'd0, 5'd6, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        chk("illegal_xd0_noresp", 64'(seen), 64'd0);
        chk("illegal_xd0_idle", 64'(busy), 64'd0);

        // MAC on acc0 = 10.
        send(7'h00, 64'd10, 64'd0, 5'd0, 1'b0);
        send(7'h04, 64'd7, 64'd6, 5'd4, 1'b1);
        get_resp(d, r, n);
        chk("mac_data", d, MAC_EN ? 64'd52 : 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mac_rd", 64'(r), 64'd4);
        chk("mac_latency", 64'(n), MAC_EN ? 64'(XLEN + 1) : 64'd1);
        send(7'h01, 64'd0, 64'd0, 5'd5, 1'b1);
        get_resp(d, r, n);
        chk("mac_acc0", d, MAC_EN ? 64'd52 : 64'd10);

        // Reset in the middle of a MAC: nothing comes back.
        resp_ready = 1'b0;
        send(7'h04, 64'd3, 64'd3, 5'd2, 1'b1);
        repeat (21) @(posedge clk);
        pulse_reset();
        resp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        chk("midrst_noresp", 64'(seen), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        send(7'h01, 64'd0, 64'd0, 5'd8, 1'b1);
        get_resp(d, r, n);
        chk("midrst_acc0", d, 64'd0);

        for (int i = 0; i < 10; i++) begin
            send(tbl[i].funct, tbl[i].rs1, 64'd0, tbl[i].rd, 1'b1);
            get_resp(d, r, n);
            chk($sformatf("tbl%0d_data", i), d, tbl[i].exp);
            chk($sformatf("tbl%0d_rd", i), 64'(r), 64'(tbl[i].rd));
        end

        // Randomized traffic against the model.
        @(posedge clk);
        pulse_reset();
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) begin
            rf[i]  = 7'($urandom_range(0, 127));
            ra[i]  = {$urandom, $urandom};
            rb[i]  = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 300));
            rrd[i] = 5'($urandom_range(0, 31));
            rxd[i] = 1'($urandom_range(0, 1));
            d = model(rf[i], ra[i], rb[i]);
            if (rxd[i]) begin
                exp_d.push_back(d);
                exp_r.push_back(rrd[i]);
            end
        end
        fork
            begin
                for (int i = 0; i < NR; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send(rf[i], ra[i], rb[i], rrd[i], rxd[i]);
                end
            end
            begin
                int got, cyc;
                got = 0; cyc = 0;
                while (got < exp_d.size() && cyc < 20000) begin
                    resp_ready = 1'($urandom_range(0, 1));
                    if (resp_valid && resp_ready) begin
                        chk($sformatf("rnd%0d_data", got), resp_data, exp_d[got]);
                        chk($sformatf("rnd%0d_rd", got), 64'(resp_rd), 64'(exp_r[got]));
                        got++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                chk("rnd_all_responses", 64'(got), 64'(exp_d.size()));
            end
        join
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rnd_final_idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rocc_acc_unit.md
# rocc_acc_unit

Parametrised RoCC accumulator accelerator for Ariane. It is the drop-in successor to the fixed always-ready, always-zero accelerator stub on the core's RoCC command/response interfaces. It holds NUM_ACC XLEN-bit accumulator registers and queues commands in a CMD_DEPTH-entry FIFO. It executes write, read, accumulate and clear operations, plus an optional multi-cycle multiply-accumulate. Responses use a valid/ready handshake with backpressure.

## Interface
Parameters:
- XLEN, 64, data width of operands, accumulators and response.
- NUM_ACC, 4, number of accumulators; power of two, 2..16.
- CMD_DEPTH, 2, command FIFO entries; at least 1.

Ports:
- clk_i  in  1  clock; sole clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  command accepted when valid and ready are both high; equals FIFO not full.
- cmd_funct_i  in  7  op = funct[2:0]; accumulator index = funct[3 +: log2(NUM_ACC)].
- cmd_rs1_i  in  XLEN  operand A.
- cmd_rs2_i  in  XLEN  operand B.
- cmd_rd_i  in  5  destination register, echoed in the response.
- cmd_xd_i  in  1  response required.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  core accepts the response.
- resp_data_o  out  XLEN  result.
- resp_rd_o  out  5  echoed rd.
- busy_o  out  1  FIFO non-empty or FSM not IDLE.

## Operation
- Op codes:
  - 0 WRITE: acc[i] = rs1.
  - 1 READ: acc unchanged.
  - 2 ACCUM: acc[i] += rs1.
  - 3 CLEAR: acc[i] = 0.
  - 4 MAC: acc[i] += rs1*rs2.
  - 5..7: illegal.
- Arithmetic: all results are the low XLEN bits, wrapping modulo 2^XLEN. MAC uses the low XLEN bits of the product.
- Response data is the accumulator value after the op. An illegal op returns all ones and changes no state.
- A command with xd=0 produces no response.
- The FIFO is registered:
  - No bypass; an entry is visible at the head the cycle after it is pushed.
  - cmd_ready_o depends only on fullness. A full FIFO blocks pushes even when it is popped in the same cycle.
- FSM states:
  - IDLE, head valid, single-cycle op: pop, update the accumulator, go to RESP if xd, else stay in IDLE.
  - IDLE, head valid, MAC: pop, latch operands, go to EXEC with the counter at 0.
  - EXEC: one shift-add step per cycle. At counter XLEN-1, write the accumulator and go to RESP if xd, else to IDLE.
  - RESP: hold resp_valid_o, resp_data_o and resp_rd_o stable until resp_ready_i is high, then go to IDLE. The FIFO is not popped in RESP.
- Responses are returned in command order.
- resp_ready_i may be high before resp_valid_o rises.

## Timing
- Reset values of outputs:
  - cmd_ready_o = 1.
  - resp_valid_o = 0.
  - resp_data_o = 0.
  - resp_rd_o = 0.
  - busy_o = 0.
- Reset values of state: all accumulators 0, FIFO empty, FSM in IDLE.
- Single-cycle op, accepted at edge t: executed at edge t+1; resp_valid_o is high from cycle t+2.
- Throughput:
  - xd=0: one command per cycle.
  - xd=1: at most one command per two cycles.
- MAC, popped at edge t+1: accumulator written at edge t+1+XLEN; resp_valid_o is high from cycle t+2+XLEN.
- Reset asserted mid-operation: all state clears immediately. In-flight and queued commands are dropped and no response is issued.

## Configuration
- ROCC_ACC_MAC_EN:
  - Defined: op 4 performs MAC through the EXEC state, with an XLEN-cycle iterative multiplier.
  - Undefined: EXEC and the multiplier datapath are not built; op 4 is illegal, handled as a single-cycle op returning all ones.

## Structure
- Shared package rocc_acc_pkg:
  - rocc_acc_op_e, the op enum.
  - rocc_acc_state_e: IDLE, EXEC, RESP.
  - rocc_acc_cmd_t, a struct of funct, rs1, rs2, rd and xd.
  - Op-code constants.
- Sub-module rocc_cmd_fifo: parametrised on rocc_acc_cmd_t and CMD_DEPTH, with push, pop, full and empty.
- The top level contains the FSM, the accumulator file and the optional multiplier.

## Test plan
All scenarios use XLEN=64, NUM_ACC=4, CMD_DEPTH=2.
- Reset, then READ funct=0x11 (acc2), xd=1, rd=3 -> resp_data 0, resp_rd 3; resp_valid_o high exactly 2 cycles after accept.
- WRITE funct=0x08 rs1=5 (xd=0), then ACCUM funct=0x0A rs1=0xFFFF_FFFF_FFFF_FFFE, xd=1, rd=7 -> resp_data 3 (wrap), rd 7.
- resp_ready_i held low, three READ commands with xd=1:
  - The first response is held stable.
  - cmd_ready_o drops after the FIFO holds 2.
  - Release resp_ready_i -> three responses in order.
- MAC with the macro: acc0=10, then funct=0x04, rs1=7, rs2=6, xd=1 -> 52, valid 66 cycles after accept.
  - Without the macro: all-ones response, acc0 stays 10.
- Illegal op 7:
  - xd=1 -> data 0xFFFF_FFFF_FFFF_FFFF, no accumulator changes.
  - xd=0 -> no response; busy_o returns to 0.
- rst_ni pulsed low at EXEC cycle 20 of a MAC -> no response ever; subsequent READ of acc0 returns 0.
